// File: rtl/fifo_status_pkg.sv
// Shared helpers for the fifo_status block: count width and parameter legality.
package fifo_pkg;

  function automatic int fifo_cw(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int fifo_pw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // AF_TH must be reachable (1..DEPTH); AE_TH must leave a non-almost-empty state (0..DEPTH-1).
  function automatic bit fifo_params_ok(input int depth, input int af_th, input int ae_th);
    return (depth >= 1) && (af_th >= 1) && (af_th <= depth) &&
           (ae_th >= 0) && (ae_th <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_status_if.sv
// Write/read/status bundle between a FIFO user (master) and the fifo_status buffer (slave).
interface fifo_status_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) ();
  localparam int CW = fifo_cw(DEPTH);

  logic             flush_i;
  logic             wr_en_i;
  logic [WIDTH-1:0] wr_data_i;
  logic             rd_en_i;
  logic [WIDTH-1:0] rd_data_o;
  logic             empty_o;
  logic             full_o;
  logic             almost_empty_o;
  logic             almost_full_o;
  logic [CW-1:0]    count_o;
  logic             overflow_o;
  logic             underflow_o;

  modport master (
    output flush_i, wr_en_i, wr_data_i, rd_en_i,
    input  rd_data_o, empty_o, full_o, almost_empty_o, almost_full_o,
           count_o, overflow_o, underflow_o
  );

  modport slave (
    input  flush_i, wr_en_i, wr_data_i, rd_en_i,
    output rd_data_o, empty_o, full_o, almost_empty_o, almost_full_o,
           count_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/fifo_status_mod_ptr.sv
// Modulo-DEPTH pointer with explicit wrap, so non-power-of-two depths need no extra logic.
module fifo_mod_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clr_i,
  input  logic                      inc_i,
  output logic [fifo_pw(DEPTH)-1:0] ptr_o
);
  localparam int PW = fifo_pw(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [PW-1:0] r_ptr;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_ptr <= '0;
    end else if (inc_i) begin
      r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + PW'(1);
    end
  end

  assign ptr_o = r_ptr;
endmodule

// File: rtl/fifo_status.sv
// Show-ahead single-clock FIFO with occupancy, threshold flags, flush and sticky error flags.
module fifo_status
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AF_TH = DEPTH - 1,
  parameter int AE_TH = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  fifo_status_if.slave  bus
);
  localparam int CW = fifo_cw(DEPTH);
  localparam int PW = fifo_pw(DEPTH);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_TH);
  localparam logic [CW-1:0] AE_C   = CW'(AE_TH);

  generate
    if (!fifo_params_ok(DEPTH, AF_TH, AE_TH)) begin : g_bad_params
      $error("fifo_status: illegal DEPTH/AF_TH/AE_TH combination");
    end
  endgenerate

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;
  logic [PW-1:0]    w_wptr;
  logic [PW-1:0]    w_rptr;
  logic             w_empty;
  logic             w_full;
  logic             w_tunnel;
  logic             w_wr;
  logic             w_rd;
  logic             w_ovf;
  logic             w_unf;

  // A flush cycle swallows both requests, so none of the qualified strobes fire.
  always_comb begin
    w_empty  = (r_count == '0);
    w_full   = (r_count == FULL_C);
    w_tunnel = w_empty && bus.wr_en_i && bus.rd_en_i;
    w_wr     = !bus.flush_i && bus.wr_en_i && (!w_full || bus.rd_en_i) && !w_tunnel;
    w_rd     = !bus.flush_i && bus.rd_en_i && !w_empty;
    w_ovf    = !bus.flush_i && bus.wr_en_i && w_full && !bus.rd_en_i;
    w_unf    = !bus.flush_i && bus.rd_en_i && w_empty && !bus.wr_en_i;
  end

  fifo_mod_ptr #(.DEPTH(DEPTH)) u_wptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (bus.flush_i),
    .inc_i (w_wr),
    .ptr_o (w_wptr)
  );

  fifo_mod_ptr #(.DEPTH(DEPTH)) u_rptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (bus.flush_i),
    .inc_i (w_rd),
    .ptr_o (w_rptr)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i || bus.flush_i) begin
      r_count <= '0;
    end else if (w_wr && !w_rd) begin
      r_count <= r_count + CW'(1);
    end else if (w_rd && !w_wr) begin
      r_count <= r_count - CW'(1);
    end
  end

  // Error flags stick until reset; flush deliberately leaves them alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf) r_overflow  <= 1'b1;
      if (w_unf) r_underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr && !rst_i) begin
      r_mem[w_wptr] <= bus.wr_data_i;
    end
  end

  assign bus.rd_data_o      = w_tunnel ? bus.wr_data_i : r_mem[w_rptr];
  assign bus.empty_o        = w_empty;
  assign bus.full_o         = w_full;
  assign bus.almost_empty_o = (r_count <= AE_C);
  assign bus.almost_full_o  = (r_count >= AF_C);
  assign bus.count_o        = r_count;
  assign bus.overflow_o     = r_overflow;
  assign bus.underflow_o    = r_underflow;
endmodule

// File: tb/tb_fifo_status.sv
// Bench for fifo_status: directed vector table, DEPTH=1 ping-pong, and random traffic vs. a queue model.
module tb_fifo_status;

  typedef struct {
    logic       rst;
    logic       flush;
    logic       wr;
    logic       rd;
    logic [7:0] data;
    logic       chkRd;
    logic [7:0] expRd;
    int         expCount;
    logic [5:0] expFlags;
  } vec_t;

  logic clk = 1'b0;
  logic rstA = 1'b1;
  logic rstB = 1'b1;
  int   assertCount = 0;
  int   failCount = 0;

  always #5 clk = ~clk;

  fifo_status_if #(.WIDTH(8), .DEPTH(5)) ifA ();
  fifo_status_if #(.WIDTH(8), .DEPTH(1)) ifB ();

  fifo_status #(.WIDTH(8), .DEPTH(5), .AF_TH(4), .AE_TH(1)) dutA (
    .clk_i (clk),
    .rst_i (rstA),
    .bus   (ifA.slave)
  );

  fifo_status #(.WIDTH(8), .DEPTH(1), .AF_TH(1), .AE_TH(0)) dutB (
    .clk_i (clk),
    .rst_i (rstB),
    .bus   (ifB.slave)
  );

  // Flag order used everywhere: {empty, full, almost_empty, almost_full, overflow, underflow}.
  function automatic logic [5:0] flagsA();
    return {ifA.empty_o, ifA.full_o, ifA.almost_empty_o, ifA.almost_full_o,
            ifA.overflow_o, ifA.underflow_o};
  endfunction

  function automatic logic [5:0] flagsB();
    return {ifB.empty_o, ifB.full_o, ifB.almost_empty_o, ifB.almost_full_o,
            ifB.overflow_o, ifB.underflow_o};
  endfunction

  function automatic vec_t vec(input logic rst, input logic flush, input logic wr,
                               input logic rd, input logic [7:0] data, input logic chkRd,
                               input logic [7:0] expRd, input int expCount,
                               input logic [5:0] expFlags);
    vec_t v;
    v.rst = rst; v.flush = flush; v.wr = wr; v.rd = rd; v.data = data;
    v.chkRd = chkRd; v.expRd = expRd; v.expCount = expCount; v.expFlags = expFlags;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic flush, input logic wr,
                               input logic rd, input logic [7:0] data);
    @(negedge clk);
    rstA          = rst;
    ifA.flush_i   = flush;
    ifA.wr_en_i   = wr;
    ifA.rd_en_i   = rd;
    ifA.wr_data_i = data;
    #1;
  endtask

  task automatic applyStimulusB(input logic rst, input logic wr, input logic rd,
                                input logic [7:0] data);
    @(negedge clk);
    rstB          = rst;
    ifB.flush_i   = 1'b0;
    ifB.wr_en_i   = wr;
    ifB.rd_en_i   = rd;
    ifB.wr_data_i = data;
    #1;
  endtask

  vec_t       vecs[$];
  logic [7:0] q[$];
  bit         mOvf;
  bit         mUnf;

  // Expected flags from occupancy alone, for the DEPTH=5, AF_TH=4, AE_TH=1 instance.
  function automatic logic [5:0] modelFlags(input int n, input bit ovf, input bit unf);
    return {n == 0, n == 5, n <= 1, n >= 4, ovf, unf};
  endfunction

  initial begin
    ifA.flush_i = 0; ifA.wr_en_i = 0; ifA.rd_en_i = 0; ifA.wr_data_i = '0;
    ifB.flush_i = 0; ifB.wr_en_i = 0; ifB.rd_en_i = 0; ifB.wr_data_i = '0;

    // Directed table: fill, drain, overflow, full read+write, tunnel, underflow, flush.
    vecs.push_back(vec(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 6'b101000));
    vecs.push_back(vec(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 6'b101000));
    vecs.push_back(vec(0, 0, 1, 0, 8'h10, 0, 8'h00, 1, 6'b001000));
    vecs.push_back(vec(0, 0, 1, 0, 8'h11, 1, 8'h10, 2, 6'b000000));
    vecs.push_back(vec(0, 0, 1, 0, 8'h12, 1, 8'h10, 3, 6'b000000));
    vecs.push_back(vec(0, 0, 1, 0, 8'h13, 1, 8'h10, 4, 6'b000100));
    vecs.push_back(vec(0, 0, 1, 0, 8'h14, 1, 8'h10, 5, 6'b010100));
    vecs.push_back(vec(0, 0, 0, 1, 8'h00, 1, 8'h10, 4, 6'b000100));
    vecs.push_back(vec(0, 0, 0, 1, 8'h00, 1, 8'h11, 3, 6'b000000));
    vecs.push_back(vec(0, 0, 0, 1, 8'h00, 1, 8'h12, 2, 6'b000000));
    vecs.push_back(vec(0, 0, 0, 1, 8'h00, 1, 8'h13, 1, 6'b001000));
    vecs.push_back(vec(0, 0, 0, 1, 8'h00, 1, 8'h14, 0, 6'b101000));
    vecs.push_back(vec(0, 0, 1, 0, 8'h20, 0, 8'h00, 1, 6'b001000));
    vecs.push_back(vec(0, 0, 1, 0, 8'h21, 1, 8'h20, 2, 6'b000000));
    vecs.push_back(vec(0, 0, 1, 0, 8'h22, 1, 8'h20, 3, 6'b000000));
    vecs.push_back(vec(0, 0, 1, 0, 8'h23, 1, 8'h20, 4, 6'b000100));
    vecs.push_back(vec(0, 0, 1, 0, 8'h24, 1, 8'h20, 5, 6'b010100));
    vecs.push_back(vec(0, 0, 1, 0, 8'hAA, 1, 8'h20, 5, 6'b010110));
    vecs.push_back(vec(0, 0, 0, 0, 8'h00, 1, 8'h20, 5, 6'b010110));
    vecs.push_back(vec(0, 0, 1, 1, 8'hBB, 1, 8'h20, 5, 6'b010110));
    vecs.push_back(vec(0, 0, 0, 1, 8'h00, 1, 8'h21, 4, 6'b000110));
    vecs.push_back(vec(0, 0, 0, 1, 8'h00, 1, 8'h22, 3, 6'b000010));
    vecs.push_back(vec(0, 0, 0, 1, 8'h00, 1, 8'h23, 2, 6'b000010));
    vecs.push_back(vec(0, 0, 0, 1, 8'h00, 1, 8'h24, 1, 6'b001010));
    vecs.push_back(vec(0, 0, 0, 1, 8'h00, 1, 8'hBB, 0, 6'b101010));
    vecs.push_back(vec(0, 0, 1, 1, 8'h3C, 1, 8'h3C, 0, 6'b101010));
    vecs.push_back(vec(0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 6'b101011));
    vecs.push_back(vec(0, 0, 1, 0, 8'h41, 0, 8'h00, 1, 6'b001011));
    vecs.push_back(vec(0, 0, 1, 0, 8'h42, 1, 8'h41, 2, 6'b000011));
    vecs.push_back(vec(0, 0, 1, 0, 8'h43, 1, 8'h41, 3, 6'b000011));
    vecs.push_back(vec(0, 1, 1, 0, 8'h99, 1, 8'h41, 0, 6'b101011));
    vecs.push_back(vec(0, 0, 1, 0, 8'h55, 0, 8'h00, 1, 6'b001011));
    vecs.push_back(vec(0, 0, 0, 1, 8'h00, 1, 8'h55, 0, 6'b101011));
    vecs.push_back(vec(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 6'b101000));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].flush, vecs[i].wr, vecs[i].rd, vecs[i].data);
      if (vecs[i].chkRd) checkOutput($sformatf("vec%0d rd_data", i), ifA.rd_data_o, vecs[i].expRd);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d count", i), ifA.count_o, vecs[i].expCount);
      checkOutput($sformatf("vec%0d flags", i), flagsA(), vecs[i].expFlags);
    end

    // DEPTH=1 ping-pong: one entry, so full and empty swap every cycle.
    applyStimulusB(1, 0, 0, 8'h00);
    @(posedge clk); #1;
    checkOutput("d1 reset flags", flagsB(), 6'b101000);
    for (int i = 1; i <= 8; i++) begin
      applyStimulusB(0, 1, 0, 8'(i));
      @(posedge clk); #1;
      checkOutput($sformatf("d1 wr%0d count", i), ifB.count_o, 1);
      checkOutput($sformatf("d1 wr%0d flags", i), flagsB(), 6'b010100);
      applyStimulusB(0, 0, 1, 8'h00);
      checkOutput($sformatf("d1 rd%0d data", i), ifB.rd_data_o, i);
      @(posedge clk); #1;
      checkOutput($sformatf("d1 rd%0d flags", i), flagsB(), 6'b101000);
    end
    applyStimulusB(0, 0, 0, 8'h00);

    // Random traffic with alternating write-heavy and read-heavy phases.
    q.delete(); mOvf = 0; mUnf = 0;
    for (int i = 0; i < 600; i++) begin
      logic       fl, wr, rd;
      logic [7:0] d;
      bit         heavyWr;
      heavyWr = ((i / 60) % 2) == 0;
      fl = ($urandom_range(0, 39) == 0);
      wr = ($urandom_range(0, 3) < (heavyWr ? 3 : 1));
      rd = ($urandom_range(0, 3) < (heavyWr ? 1 : 3));
      d  = 8'($urandom);
      applyStimulus(0, fl, wr, rd, d);
      if (q.size() == 0 && wr && rd) checkOutput($sformatf("rand%0d tunnel", i), ifA.rd_data_o, d);
      else if (q.size() > 0) checkOutput($sformatf("rand%0d head", i), ifA.rd_data_o, q[0]);
      if (fl) begin
        q.delete();
      end else if (!(q.size() == 0 && wr && rd)) begin
        if (wr && q.size() == 5 && !rd) mOvf = 1;
        if (rd && q.size() == 0 && !wr) mUnf = 1;
        if (rd && q.size() > 0) begin
          q.pop_front();
          if (wr) q.push_back(d);
        end else if (wr && q.size() < 5) begin
          q.push_back(d);
        end
      end
      @(posedge clk); #1;
      checkOutput($sformatf("rand%0d count", i), ifA.count_o, q.size());
      checkOutput($sformatf("rand%0d flags", i), flagsA(), modelFlags(q.size(), mOvf, mUnf));
    end

    // Reset must clear sticky flags no matter what the random run left behind.
    applyStimulus(1, 0, 0, 0, 8'h00);
    @(posedge clk); #1;
    checkOutput("final reset flags", flagsA(), 6'b101000);
    checkOutput("final reset count", ifA.count_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/fifo_status.md
# fifo_status

Synchronous single-clock show-ahead FIFO with arbitrary (non-power-of-two) depth, occupancy count, programmable almost-full/almost-empty thresholds, a synchronous flush and sticky overflow/underflow error flags. It is the next-generation general buffer for streaming datapaths that need back-pressure ahead of full, and error visibility for firmware status registers. Bypass ("tunnel") behaviour on an empty FIFO is retained.

## Interface
- WIDTH, 8: data word width in bits, ≥1.
- DEPTH, 16: number of storage entries, ≥1, any integer (no power-of-two requirement).
- AF_TH, DEPTH-1: almost_full_o asserts when count ≥ AF_TH; legal range 1..DEPTH.
- AE_TH, 1: almost_empty_o asserts when count ≤ AE_TH; legal range 0..DEPTH-1.
- CW (localparam): $clog2(DEPTH+1), width of count_o.

- clk_i  in  1  sole clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  synchronous empty; discards contents.
- wr_en_i  in  1  write request.
- wr_data_i  in  WIDTH  write data.
- rd_en_i  in  1  read/pop request; rd_data_o is consumed in the same cycle.
- rd_data_o  out  WIDTH  head-of-queue data (show-ahead).
- empty_o / full_o  out  1  count==0 / count==DEPTH.
- almost_empty_o / almost_full_o  out  1  threshold flags.
- count_o  out  CW  current occupancy.
- overflow_o / underflow_o  out  1  sticky error flags.

## Operation
- State: mem[DEPTH], wptr/rptr (range 0..DEPTH-1, wrap DEPTH-1→0), count register 0..DEPTH, two sticky bits.
- Priority per cycle: rst_i > flush_i > normal.
- rst_i: pointers 0, count 0, overflow_o/underflow_o 0. Memory contents not reset.
- flush_i: pointers 0, count 0; wr_en_i/rd_en_i ignored that cycle; no error flag set; sticky flags keep their value.
- Tunnel (empty_o & wr_en_i & rd_en_i): rd_data_o = wr_data_i combinationally; no memory write; pointers and count unchanged; no error.
- Write accepted when wr_en_i & (~full_o | rd_en_i) and not tunnel: mem[wptr] ← wr_data_i, wptr advances.
- Read accepted when rd_en_i & ~empty_o: rptr advances.
- count: +1 on write-only, −1 on read-only, unchanged on both or neither. Full with simultaneous read and write is legal; count stays DEPTH.
- Overflow: wr_en_i & full_o & ~rd_en_i → write dropped, overflow_o set (sticky until rst_i).
- Underflow: rd_en_i & empty_o & ~wr_en_i → no state change, underflow_o set (sticky until rst_i).
- rd_data_o = mem[rptr] when not tunnelling. The value while empty and not tunnelling is unspecified and must not be checked.
- All flags and count_o decode from registered state only. They never depend combinationally on inputs.

## Timing
- Reset values: count_o 0, empty_o 1, full_o 0, almost_empty_o 1, almost_full_o 0, overflow_o 0, underflow_o 0.
- Write-to-visible latency: 1 cycle. Data written at edge N is on rd_data_o and reflected in count_o after edge N.
- Tunnel latency: 0 cycles (combinational).
- Pop: head advances on the edge where rd_en_i & ~empty_o is sampled.
- Flags update on the same edge as count.
- Flush and reset take effect on the next edge; the FIFO is writable in the following cycle.

## Structure
- Package fifo_pkg: function fifo_cw(depth) returning $clog2(depth+1), and the parameter range checks (elaboration-time $error on illegal AF_TH/AE_TH/DEPTH).
- Sub-module fifo_mod_ptr: parameter DEPTH; clk_i, rst_i, clr_i, inc_i, ptr_o. It is a modulo-DEPTH counter that wraps explicitly and is instantiated twice, for wptr and rptr.
- DEPTH==1 uses the same code path, with a 1-bit pointer fixed at 0.

## Test plan
Unless noted, WIDTH=8, DEPTH=5, AF_TH=4, AE_TH=1.
- Reset, then idle: all outputs at reset values; count_o=0, empty_o=1, almost_empty_o=1.
- Write 0x10..0x14 on 5 consecutive cycles: count_o 1,2,3,4,5; almost_empty_o drops at count 2; almost_full_o rises at 4; full_o rises at 5. Then pop 5 times: data 0x10..0x14 in order, wrapping correctly.
- When full: wr_en_i alone with 0xAA → dropped, overflow_o=1 and stays 1. Then read+write 0xBB → count stays 5, 0xBB is emerged after 4 further pops.
- When empty: wr_en_i+rd_en_i with 0x3C → rd_data_o=0x3C the same cycle, count_o stays 0. Then rd_en_i alone → underflow_o=1, count_o=0.
- Fill 3 entries, assert flush_i together with wr_en_i → next cycle count_o=0, empty_o=1, sticky flags unchanged. A subsequent write of 0x55 reads back 0x55.
- DEPTH=1, AF_TH=1, AE_TH=0: alternating write and read of 0x01..0x08 → correct order, full_o/empty_o toggle each cycle, no error flags.
